// File: rtl/gpu_loader_if.sv
// Purpose: bundles the loader's control, RAM read port and buffer write port.
// Modports: master = loader side, slave = environment (sequencer, RAM arbiter, buffer).
// Signals: start/base_addr/busy/done, mem_req/mem_gnt/mem_addr/mem_dout,
//          buf_we/buf_addr/buf_din; abort exists only with GPU_LOADER_ABORT_EN.
interface gpu_loader_if #(
  parameter int ADDR_WIDTH     = 4,
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = 13
);
  logic                      start;
  logic [MEM_ADDR_WIDTH-1:0] base_addr;
  logic                      busy;
  logic                      done;
  logic                      mem_req;
  logic                      mem_gnt;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr;
  logic [DATA_WIDTH-1:0]     mem_dout;
  logic                      buf_we;
  logic [ADDR_WIDTH-1:0]     buf_addr;
  logic [DATA_WIDTH-1:0]     buf_din;
`ifdef GPU_LOADER_ABORT_EN
  logic                      abort;

  modport master (
    input  start, base_addr, mem_gnt, mem_dout, abort,
    output busy, done, mem_req, mem_addr, buf_we, buf_addr, buf_din
  );
  modport slave (
    output start, base_addr, mem_gnt, mem_dout, abort,
    input  busy, done, mem_req, mem_addr, buf_we, buf_addr, buf_din
  );
`else
  modport master (
    input  start, base_addr, mem_gnt, mem_dout,
    output busy, done, mem_req, mem_addr, buf_we, buf_addr, buf_din
  );
  modport slave (
    output start, base_addr, mem_gnt, mem_dout,
    input  busy, done, mem_req, mem_addr, buf_we, buf_addr, buf_din
  );
`endif
endinterface

// File: rtl/gpu_loader.sv
// Purpose: copies SIZE consecutive RAM words (from a latched base) into object buffer entries 0..SIZE-1.
// Latency: SIZE+2 cycles from start to done with continuous grant; each grant-low FETCH cycle adds one.
// Backpressure: mem_gnt low stalls issue with mem_addr held; accepted reads always complete their write.
// Ports: clk, reset (async, active-high); bus (gpu_loader_if.master) carries start/base_addr/busy/done,
//        the shared RAM read port (mem_req/mem_gnt/mem_addr/mem_dout) and the buffer write port.
// Option: GPU_LOADER_ABORT_EN adds bus.abort, which cancels a running transfer without a done pulse.
module gpu_loader #(
  parameter int ADDR_WIDTH     = 4,
  parameter int SIZE           = 16,
  parameter int DATA_WIDTH     = 16,
  parameter int MEM_ADDR_WIDTH = 13
) (
  input  logic         clk,
  input  logic         reset,
  gpu_loader_if.master bus
);
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_DRAIN, S_DONE} state_t;

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(SIZE - 1);

  state_t                    state_q, state_d;
  logic [ADDR_WIDTH-1:0]     issue_idx_q, issue_idx_d;
  logic [MEM_ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic                      mem_req_q, mem_req_d;
  logic                      busy_q, busy_d;
  logic                      done_q, done_d;
  // One-deep read pipeline: an accepted address becomes a buffer write next cycle.
  logic                      pend_vld_q, pend_vld_d;
  logic [ADDR_WIDTH-1:0]     pend_idx_q, pend_idx_d;

  logic accept;
  logic abort_in;
  logic start_ok;
  logic abort_req;

  assign accept = mem_req_q && bus.mem_gnt;

`ifdef GPU_LOADER_ABORT_EN
  assign abort_in = bus.abort;
`else
  assign abort_in = 1'b0;
`endif

  // Abort beats a simultaneous start; it only acts while a transfer is running.
  assign start_ok  = bus.start && !abort_in;
  assign abort_req = abort_in && busy_q;

  always_comb begin
    state_d     = state_q;
    issue_idx_d = issue_idx_q;
    mem_addr_d  = mem_addr_q;
    mem_req_d   = mem_req_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    pend_vld_d  = accept;
    pend_idx_d  = accept ? issue_idx_q : '0;

    case (state_q)
      S_IDLE: begin
        if (start_ok) begin
          state_d     = S_FETCH;
          issue_idx_d = '0;
          mem_addr_d  = bus.base_addr;
          mem_req_d   = 1'b1;
          busy_d      = 1'b1;
        end
      end
      S_FETCH: begin
        if (accept) begin
          // Address wraps naturally at 2^MEM_ADDR_WIDTH.
          mem_addr_d  = mem_addr_q + MEM_ADDR_WIDTH'(1);
          issue_idx_d = issue_idx_q + ADDR_WIDTH'(1);
          if (issue_idx_q == LAST_IDX) begin
            state_d   = S_DRAIN;
            mem_req_d = 1'b0;
          end
        end
      end
      S_DRAIN: begin
        // The last accepted read is being written this cycle.
        if (pend_vld_q) begin
          state_d = S_DONE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (abort_req) begin
      state_d    = S_IDLE;
      mem_req_d  = 1'b0;
      busy_d     = 1'b0;
      done_d     = 1'b0;
      pend_vld_d = 1'b0;
      pend_idx_d = '0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      issue_idx_q <= '0;
      mem_addr_q  <= '0;
      mem_req_q   <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_idx_q  <= '0;
    end else begin
      state_q     <= state_d;
      issue_idx_q <= issue_idx_d;
      mem_addr_q  <= mem_addr_d;
      mem_req_q   <= mem_req_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      pend_vld_q  <= pend_vld_d;
      pend_idx_q  <= pend_idx_d;
    end
  end

  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.mem_req  = mem_req_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.buf_we   = pend_vld_q;
  assign bus.buf_addr = pend_idx_q;
  // RAM data arrives the cycle after accept, so it passes straight through to the buffer.
  assign bus.buf_din  = pend_vld_q ? bus.mem_dout : {DATA_WIDTH{1'b0}};
endmodule

// File: tb/tb_gpu_loader.sv
`timescale 1ns/1ps
module tb_gpu_loader;
  localparam int AW = 4, SZ = 16, DW = 16, MAW = 13;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  gpu_loader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW)) bus ();

  gpu_loader #(.ADDR_WIDTH(AW), .SIZE(SZ), .DATA_WIDTH(DW), .MEM_ADDR_WIDTH(MAW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int tests_run = 0;
  int tests_failed = 0;
  int cyc = 0;
  int viol = 0;
  int done_cnt = 0;

  int            wr_idx[$];
  logic [DW-1:0] wr_dat[$];
  int            wr_cyc[$];
  logic [MAW-1:0] acc_addr[$];
  logic [DW-1:0] tb_buf [SZ];

  logic           prev_req = 1'b0;
  logic           prev_gnt = 1'b0;
  logic [MAW-1:0] prev_addr = '0;

  // RAM contents: RAM[a] = 0x9F00 + a, so RAM[0x100+i] = 0xA000+i.
  function automatic logic [DW-1:0] ram_val(input logic [MAW-1:0] a);
    return 16'h9F00 + {3'b000, a};
  endfunction

  // RAM read port: one-cycle latency, garbage when no address was accepted.
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.mem_req && bus.mem_gnt) begin
      bus.mem_dout <= ram_val(bus.mem_addr);
      acc_addr.push_back(bus.mem_addr);
    end else begin
      bus.mem_dout <= 16'hDEAD;
    end
    prev_req  <= bus.mem_req;
    prev_gnt  <= bus.mem_gnt;
    prev_addr <= bus.mem_addr;
  end

  always @(negedge clk) begin
    if (bus.buf_we) begin
      wr_idx.push_back(int'(bus.buf_addr));
      wr_dat.push_back(bus.buf_din);
      wr_cyc.push_back(cyc);
      tb_buf[bus.buf_addr] = bus.buf_din;
      if (!bus.busy) viol++;
    end
    if (bus.done) begin
      done_cnt++;
      if (bus.busy) viol++;
    end
    if (prev_req && !prev_gnt && bus.mem_req && bus.mem_addr != prev_addr) viol++;
  end

  task automatic clear_logs();
    wr_idx.delete();
    wr_dat.delete();
    wr_cyc.delete();
    acc_addr.delete();
  endtask

  // Starts a transfer at the next negedge; grant follows pat LSB-first from cycle T+1.
  // inj_k >= 0 pulses start (different base) at loop step inj_k. Returns tdone = -1 on timeout.
  task automatic run_xfer(input logic [MAW-1:0] base, input logic [47:0] pat, input int inj_k,
                          output int t0, output int tdone, output logic [MAW+1:0] snap);
    logic [47:0] p;
    p = pat;
    snap = '0;
    tdone = -1;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = base;
    t0 = cyc;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (k == 0) snap = {bus.busy, bus.mem_req, bus.mem_addr};
      bus.start = (k == inj_k);
      bus.base_addr = (k == inj_k) ? (base ^ 13'h0AAA) : (base ^ 13'h1555);
      bus.mem_gnt = p[0];
      p = {1'b1, p[47:1]};
      if (bus.done) begin
        tdone = cyc;
        break;
      end
    end
    bus.start = 1'b0;
    bus.mem_gnt = 1'b1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    tests_run++; if (bus.busy !== 1'b0) begin tests_failed++; $display("FAIL rst_busy: got %b expected 0", bus.busy); end
    tests_run++; if (bus.done !== 1'b0) begin tests_failed++; $display("FAIL rst_done: got %b expected 0", bus.done); end
    tests_run++; if (bus.mem_req !== 1'b0) begin tests_failed++; $display("FAIL rst_mem_req: got %b expected 0", bus.mem_req); end
    tests_run++; if (bus.mem_addr !== 13'h0) begin tests_failed++; $display("FAIL rst_mem_addr: got %h expected 0", bus.mem_addr); end
    tests_run++; if (bus.buf_we !== 1'b0) begin tests_failed++; $display("FAIL rst_buf_we: got %b expected 0", bus.buf_we); end
    tests_run++; if (bus.buf_addr !== 4'h0) begin tests_failed++; $display("FAIL rst_buf_addr: got %h expected 0", bus.buf_addr); end
    tests_run++; if (bus.buf_din !== 16'h0) begin tests_failed++; $display("FAIL rst_buf_din: got %h expected 0", bus.buf_din); end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_continuous();
    int t0, td, v0, bad;
    logic [MAW+1:0] snap;
    clear_logs();
    v0 = viol;
    run_xfer(13'h100, {48{1'b1}}, -1, t0, td, snap);
    tests_run++; if (snap !== {2'b11, 13'h100}) begin tests_failed++; $display("FAIL cont_first_cycle: got %h expected %h", snap, {2'b11, 13'h100}); end
    tests_run++; if (td !== t0 + 18) begin tests_failed++; $display("FAIL cont_done_cycle: got %0d expected %0d", td - t0, 18); end
    @(negedge clk);
    tests_run++; if (bus.done !== 1'b0 || bus.busy !== 1'b0) begin tests_failed++; $display("FAIL cont_after_done: got done=%b busy=%b expected 0 0", bus.done, bus.busy); end
    tests_run++; if (wr_idx.size() != 16) begin tests_failed++; $display("FAIL cont_write_count: got %0d expected 16", wr_idx.size()); end
    for (int i = 0; i < 16 && i < wr_idx.size(); i++) begin
      tests_run++;
      if (wr_idx[i] !== i || wr_dat[i] !== (16'hA000 + 16'(i)) || wr_cyc[i] !== t0 + 2 + i) begin
        tests_failed++;
        $display("FAIL cont_write%0d: got idx=%0d dat=%h cyc=T+%0d expected idx=%0d dat=%h cyc=T+%0d",
                 i, wr_idx[i], wr_dat[i], wr_cyc[i] - t0, i, 16'hA000 + 16'(i), 2 + i);
      end
    end
    bad = viol - v0;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL cont_protocol: got %0d violations expected 0", bad); end
  endtask

  task automatic test_stall();
    int t0, td, v0, bad;
    logic [MAW+1:0] snap;
    clear_logs();
    v0 = viol;
    // Grant 1,0,0,1,1,0,1,1,...: ten low cycles occur before the 16th accept.
    run_xfer(13'h100, 48'hFFFFF39D39D9, -1, t0, td, snap);
    tests_run++; if (td !== t0 + 28) begin tests_failed++; $display("FAIL stall_done_cycle: got %0d expected %0d", td - t0, 28); end
    tests_run++; if (wr_idx.size() != 16) begin tests_failed++; $display("FAIL stall_write_count: got %0d expected 16", wr_idx.size()); end
    bad = 0;
    for (int i = 0; i < wr_idx.size(); i++)
      if (wr_idx[i] !== i || wr_dat[i] !== (16'hA000 + 16'(i))) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL stall_data: got %0d bad writes expected 0", bad); end
    bad = viol - v0;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL stall_addr_stable: got %0d violations expected 0", bad); end
  endtask

  task automatic test_wrap();
    int t0, td;
    logic [MAW+1:0] snap;
    clear_logs();
    run_xfer(13'h1FFE, {48{1'b1}}, -1, t0, td, snap);
    tests_run++; if (td !== t0 + 18) begin tests_failed++; $display("FAIL wrap_done_cycle: got %0d expected 18", td - t0); end
    tests_run++;
    if (acc_addr.size() < 3 || acc_addr[0] !== 13'h1FFE || acc_addr[1] !== 13'h1FFF || acc_addr[2] !== 13'h0000) begin
      tests_failed++;
      $display("FAIL wrap_addr_seq: got %0d addrs first=%h expected 1ffe,1fff,0000", acc_addr.size(), (acc_addr.size() > 0) ? acc_addr[0] : 13'h0);
    end
    tests_run++;
    if (wr_dat.size() < 3 || wr_dat[0] !== 16'hBEFE || wr_dat[2] !== 16'h9F00) begin
      tests_failed++;
      $display("FAIL wrap_data: got %0d writes expected idx0=befe idx2=9f00", wr_dat.size());
    end
  endtask

  task automatic test_back_to_back();
    int t0, td, t1, td1, bad;
    logic [MAW+1:0] snap;
    clear_logs();
    run_xfer(13'h040, {48{1'b1}}, 5, t0, td, snap);
    tests_run++; if (wr_idx.size() != 16) begin tests_failed++; $display("FAIL b2b_ignored_start_count: got %0d expected 16", wr_idx.size()); end
    bad = 0;
    for (int i = 0; i < wr_idx.size(); i++)
      if (wr_idx[i] !== i || wr_dat[i] !== ram_val(13'h040 + 13'(i))) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL b2b_ignored_start_data: got %0d bad writes expected 0", bad); end
    clear_logs();
    run_xfer(13'h080, {48{1'b1}}, -1, t1, td1, snap);
    tests_run++; if (t1 !== td + 1) begin tests_failed++; $display("FAIL b2b_start_cycle: got %0d expected %0d", t1 - td, 1); end
    tests_run++; if (td1 !== t1 + 18) begin tests_failed++; $display("FAIL b2b_done_cycle: got %0d expected 18", td1 - t1); end
    bad = 0;
    for (int i = 0; i < wr_idx.size(); i++)
      if (wr_idx[i] !== i || wr_dat[i] !== ram_val(13'h080 + 13'(i)) || wr_cyc[i] !== t1 + 2 + i) bad++;
    tests_run++; if (bad != 0 || wr_idx.size() != 16) begin tests_failed++; $display("FAIL b2b_second_data: got %0d bad of %0d expected 0 of 16", bad, wr_idx.size()); end
  endtask

  task automatic test_reset_mid();
    int t0, td, d0, bad;
    logic found;
    logic [MAW+1:0] snap;
    found = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = 13'h200;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      bus.mem_gnt = 1'b1;
      if (bus.buf_we && bus.buf_addr == 4'd7) begin
        found = 1'b1;
        break;
      end
    end
    tests_run++; if (found !== 1'b1) begin tests_failed++; $display("FAIL rmid_reach_write7: got %b expected 1", found); end
    d0 = done_cnt;
    #1 reset = 1'b1;
    #1;
    tests_run++;
    if ({bus.busy, bus.done, bus.mem_req, bus.mem_addr, bus.buf_we, bus.buf_addr, bus.buf_din} !== '0) begin
      tests_failed++;
      $display("FAIL rmid_outputs_cleared: got busy=%b done=%b req=%b addr=%h we=%b idx=%h din=%h expected all 0",
               bus.busy, bus.done, bus.mem_req, bus.mem_addr, bus.buf_we, bus.buf_addr, bus.buf_din);
    end
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++; if (done_cnt != d0) begin tests_failed++; $display("FAIL rmid_no_done: got %0d pulses expected 0", done_cnt - d0); end
    clear_logs();
    run_xfer(13'h300, {48{1'b1}}, -1, t0, td, snap);
    tests_run++; if (td !== t0 + 18) begin tests_failed++; $display("FAIL rmid_refill_done: got %0d expected 18", td - t0); end
    bad = 0;
    for (int i = 0; i < SZ; i++)
      if (tb_buf[i] !== ram_val(13'h300 + 13'(i))) bad++;
    tests_run++; if (bad != 0) begin tests_failed++; $display("FAIL rmid_overwrite: got %0d stale entries expected 0", bad); end
  endtask

`ifdef GPU_LOADER_ABORT_EN
  task automatic test_abort();
    int d0;
    logic found;
    found = 1'b0;
    @(negedge clk);
    bus.start = 1'b1;
    bus.base_addr = 13'h100;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.buf_we && bus.buf_addr == 4'd5) begin
        found = 1'b1;
        break;
      end
    end
    d0 = done_cnt;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    tests_run++;
    if (!found || bus.mem_req !== 1'b0 || bus.busy !== 1'b0 || bus.buf_we !== 1'b0) begin
      tests_failed++;
      $display("FAIL abort_stop: got found=%b req=%b busy=%b we=%b expected 1 0 0 0", found, bus.mem_req, bus.busy, bus.buf_we);
    end
    repeat (4) @(negedge clk);
    tests_run++; if (done_cnt != d0) begin tests_failed++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_cnt - d0); end
  endtask
`endif

  initial begin
    bus.start = 1'b0;
    bus.base_addr = '0;
    bus.mem_gnt = 1'b1;
`ifdef GPU_LOADER_ABORT_EN
    bus.abort = 1'b0;
`endif
    for (int i = 0; i < SZ; i++) tb_buf[i] = 16'h0;
    test_reset();
    test_continuous();
    test_stall();
    test_wrap();
    test_back_to_back();
    test_reset_mid();
`ifdef GPU_LOADER_ABORT_EN
    test_abort();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end
endmodule

// File: doc/gpu_loader.md
# gpu_loader

Fills the GPU's multi-read, single-write object buffer from main RAM before each frame. On a start pulse (issued at frame start by the video timing logic), it copies SIZE consecutive words from RAM, beginning at a latched base address, into buffer entries 0..SIZE-1. It shares the RAM read port with the CPU through a request/grant handshake and tolerates grant being withdrawn at any cycle. It is the only writer of the buffer.

## Interface
Parameters:
- ADDR_WIDTH, 4, buffer index width
- SIZE, 16, number of buffer words per transfer (≤ 2^ADDR_WIDTH)
- DATA_WIDTH, 16, word width
- MEM_ADDR_WIDTH, 13, RAM address width

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  one-cycle request to begin a transfer
- base_addr  in  MEM_ADDR_WIDTH  RAM address of word 0, sampled with start
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse after last buffer write
- mem_req  out  1  request RAM read port
- mem_gnt  in  1  read port granted this cycle (address accepted)
- mem_addr  out  MEM_ADDR_WIDTH  RAM read address
- mem_dout  in  DATA_WIDTH  RAM read data, valid the cycle after an accepted address
- buf_we  out  1  buffer write enable
- buf_addr  out  ADDR_WIDTH  buffer write index
- buf_din  out  DATA_WIDTH  buffer write data

## Operation
- FSM states:
  - IDLE → FETCH on start; base_addr is latched and the issue counter is cleared.
  - FETCH → DRAIN when index SIZE-1 is accepted (mem_req && mem_gnt).
  - DRAIN → DONE after the final in-flight write.
  - DONE → IDLE unconditionally.
- FETCH:
  - mem_req=1, mem_addr = base + issue_idx, truncated modulo 2^MEM_ADDR_WIDTH (RAM address wrap-around is legal).
  - issue_idx increments only on accept. mem_gnt=0 stalls with address held stable.
- Read pipeline:
  - An accept sets a 1-deep valid flag with the captured index.
  - Next cycle: buf_we=1, buf_addr=captured index, buf_din=mem_dout.
  - The write happens regardless of current grant.
- Writes occur in index order, exactly once each; no duplicate or skipped indices under any grant pattern.
- start while busy or in DONE is ignored. base_addr changes after the start cycle have no effect.
- mem_req=0 in IDLE, DRAIN, DONE.
- Reset mid-transfer:
  - All outputs clear immediately. The in-flight write is lost.
  - Buffer keeps partial contents, since the buffer has no reset; the next full transfer overwrites them.

## Timing
- Reset values: busy=0, done=0, mem_req=0, mem_addr=0, buf_we=0, buf_addr=0, buf_din=0. FSM=IDLE.
- start sampled high at edge T → busy=1 and mem_req=1 with mem_addr=base from cycle T+1.
- With continuous grant:
  - Word i is written in cycle T+2+i.
  - The last write is in cycle T+1+SIZE.
  - done=1 in cycle T+2+SIZE with busy=0 in that cycle.
  - Total: SIZE+2 cycles from start to done.
- Each grant-low cycle during FETCH adds exactly one cycle to the timeline.
- busy=1 from T+1 through the last write cycle inclusive.
- start may be accepted the cycle after done (back-to-back transfers).

## Configuration
- GPU_LOADER_ABORT_EN defined:
  - Adds input port abort (1 bit).
  - abort=1 in any busy cycle: mem_req drops next cycle, any in-flight write is suppressed, FSM returns to IDLE, no done pulse.
  - abort in IDLE/DONE has no effect. abort has priority over a simultaneous start.
- Not defined: no abort port; a transfer always runs to done or reset.

## Test plan
- Transfer with continuous grant: RAM[0x100+i]=0xA000+i, base=0x100, SIZE=16 → buf writes idx 0..15 with 0xA000..0xA00F in cycles T+2..T+17, done at T+18.
- Grant toggled 1,0,0,1,… (pseudo-random) → identical buffer contents; done delayed by exactly the number of grant-low FETCH cycles; mem_addr stable while stalled.
- Wrap: base=0x1FFE, MEM_ADDR_WIDTH=13 → mem_addr sequence 0x1FFE, 0x1FFF, 0x0000, …; buf idx 2 gets RAM[0x0000].
- start pulsed during busy with a different base → ignored, no extra writes. start the cycle after done → second transfer begins normally.
- Reset asserted asynchronously at write 7 → outputs zero immediately, no done. Full transfer afterwards overwrites all 16 entries.
- With GPU_LOADER_ABORT_EN, abort at the cycle of write 5 → write 5 suppressed if still in flight, mem_req=0 next cycle, busy=0, no done pulse.
